// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter and its round-robin grant logic.
package div_pkg;

  localparam int unsigned NUM_CLIENTS = 2;

  // Divide-by-zero quotient is this bit replicated across the result width (all ones).
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic logic [NUM_CLIENTS-1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational grant, registered pointer to the client served last.
module rr_arbiter2
  import div_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   en,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic                   gnt_idx
);

  logic last_gnt;
  logic fav;

  // Favour the client not served last; fall back to the other one if it is idle.
  always_comb begin
    fav     = ~last_gnt;
    gnt_idx = fav;
    if (!req[fav]) gnt_idx = ~fav;
    gnt = (en && (req != '0)) ? client_onehot(gnt_idx) : '0;
  end

  // A grant is always accepted because ready equals grant and grant implies valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (en && (req != '0)) begin
      last_gnt <= gnt_idx;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates two clients onto one iterative divider, resolving divide-by-zero locally and
// aborting a divider that never reports a result.
module div_arbiter
  import div_pkg::*;
#(
  parameter int unsigned parallelism = 32,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_signed,
  input  logic [2*parallelism-1:0] req_dividend,
  input  logic [2*parallelism-1:0] req_divisor,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [parallelism-1:0]   rsp_quotient,
  output logic [parallelism-1:0]   rsp_remainder,
  output logic                     rsp_dbz,
  output logic                     rsp_err,
  output logic                     div_valid,
  output logic                     div_usigned_n,
  output logic [parallelism-1:0]   div_dividend,
  output logic [parallelism-1:0]   div_divisor,
  input  logic [parallelism-1:0]   div_quotient,
  input  logic [parallelism-1:0]   div_reminder,
  input  logic                     div_res_ready
);

  localparam int unsigned W  = parallelism;
  localparam int unsigned CW = $clog2(TIMEOUT);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          cur;
  logic          gnt_idx;
  logic [1:0]    gnt;
  logic          accept;
  logic [W-1:0]  sel_dividend;
  logic [W-1:0]  sel_divisor;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (state == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    req_ready    = gnt;
    accept       = (gnt & req_valid) != 2'b00;
    sel_dividend = gnt_idx ? req_dividend[2*W-1:W] : req_dividend[W-1:0];
    sel_divisor  = gnt_idx ? req_divisor[2*W-1:W]  : req_divisor[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cur           <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_err       <= 1'b0;
      div_valid     <= 1'b0;
      div_usigned_n <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      div_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur           <= gnt_idx;
            div_dividend  <= sel_dividend;
            div_divisor   <= sel_divisor;
            div_usigned_n <= req_signed[gnt_idx];
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
            // A zero divisor is answered here without ever starting the divider.
            if (sel_divisor == '0) begin
              rsp_quotient  <= {W{DBZ_QUOTIENT_BIT}};
              rsp_remainder <= sel_dividend;
              rsp_dbz       <= 1'b1;
              rsp_valid     <= client_onehot(gnt_idx);
              state         <= RESP;
            end else begin
              div_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (div_res_ready) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_reminder;
            rsp_valid     <= client_onehot(cur);
            state         <= RESP;
          end else if (cnt == CW'(TIMEOUT - 2)) begin
            // Counter would reach TIMEOUT-1 on this edge: give up on the divider.
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= 1'b1;
            rsp_valid     <= client_onehot(cur);
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[cur]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
